commit_trace_buffer: RTL and testbench

- Downstream consumer of the pipelined RV32I core's retire (writeback) stage.
- Captures one record per retired instruction (PC, instruction word, destination register write) into a circular buffer.
- Supports a PC-match trigger that freezes capture a fixed number of commits after the trigger.
- The testbench or a debug host drains records through a pop interface, replacing free-running $monitor prints with ordered, lossless-or-counted retire traces.

---
 rtl/commit_trace_buffer.sv | 164 ++++++++++++++++
 tb/tb_commit_trace_buffer.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/commit_trace_buffer.sv
// Retire-stage trace buffer: captures one record per committed instruction into a
// circular buffer, with a PC trigger that freezes capture POST_TRIG commits later.
// Optional macro TRACE_SKIP_NOP_EN drops canonical NOPs from capture and countdown.
module commit_trace_buffer #(
  parameter int DEPTH     = 16,
  parameter int POST_TRIG = 4,
  parameter int XLEN      = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       commit_valid,
  input  logic [XLEN-1:0]            commit_pc,
  input  logic [31:0]                commit_instr,
  input  logic                       commit_rd_we,
  input  logic [4:0]                 commit_rd,
  input  logic [XLEN-1:0]            commit_rd_data,
  input  logic                       trig_en,
  input  logic [XLEN-1:0]            trig_pc,
  input  logic                       clear,
  input  logic                       rd_req,
  output logic                       rd_valid,
  output logic [XLEN-1:0]            rd_pc,
  output logic [31:0]                rd_instr,
  output logic                       rd_we,
  output logic [4:0]                 rd_rd,
  output logic [XLEN-1:0]            rd_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty,
  output logic [15:0]                overflow_cnt,
  output logic                       triggered,
  output logic                       frozen
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] POST_LOAD = AW'(POST_TRIG);

  typedef enum logic [1:0] {CAPTURE, POST, FREEZE} state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic            we;
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          rd_q;
  state_t          state_q, state_d;
  logic [AW-1:0]   wr_ptr, rd_ptr, post_cnt;
  logic [CW-1:0]   count_q, count_d;
  logic            is_nop, live, pop, push, drop, trig_hit, post_tick;

`ifdef TRACE_SKIP_NOP_EN
  assign is_nop = (commit_instr == 32'h0000_0013);
`else
  assign is_nop = 1'b0;
`endif

  // clear squashes any same-cycle push or pop, so it is folded in here once.
  assign live      = (state_q != FREEZE);
  assign pop       = !clear && rd_req && !empty;
  assign push      = !clear && live && commit_valid && !is_nop && (!full || pop);
  assign drop      = !clear && live && commit_valid && !is_nop && full && !pop;
  assign trig_hit  = !clear && (state_q == CAPTURE) && commit_valid && trig_en
                     && (commit_pc == trig_pc);
  assign post_tick = !clear && (state_q == POST) && commit_valid && !is_nop;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= CAPTURE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      CAPTURE: if (trig_hit) state_d = (POST_TRIG == 0) ? FREEZE : POST;
      POST:    if (post_tick && post_cnt == AW'(1)) state_d = FREEZE;
      FREEZE:  state_d = FREEZE;
      default: state_d = CAPTURE;
    endcase
    if (clear) state_d = CAPTURE;
  end

  // Output logic
  always_comb begin
    frozen = (state_q == FREEZE);
  end

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (clear) count_d = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    // NOTE: non-blocking assignments keep every register updating from pre-edge values.
    if (!reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      post_cnt     <= '0;
      count_q      <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      overflow_cnt <= '0;
      triggered    <= 1'b0;
      rd_valid     <= 1'b0;
      rd_q         <= '0;
    end else begin
      count_q  <= count_d;
      full     <= (count_d == CW'(DEPTH));
      empty    <= (count_d == '0);
      rd_valid <= pop;
      if (clear) begin
        wr_ptr       <= '0;
        rd_ptr       <= '0;
        post_cnt     <= '0;
        overflow_cnt <= '0;
        triggered    <= 1'b0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop) begin
          rd_ptr <= rd_ptr + AW'(1);
          rd_q   <= mem[rd_ptr];
        end
        if (drop && overflow_cnt != 16'hFFFF) overflow_cnt <= overflow_cnt + 16'd1;
        if (trig_hit) begin
          triggered <= 1'b1;
          post_cnt  <= POST_LOAD;
        end else if (post_tick) begin
          post_cnt <= post_cnt - AW'(1);
        end
      end
    end
  end

  // NOTE: storage has no reset; pointers and count alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr].pc    <= commit_pc;
      mem[wr_ptr].instr <= commit_instr;
      mem[wr_ptr].we    <= commit_rd_we && (commit_rd != 5'd0);
      mem[wr_ptr].rd    <= commit_rd;
      mem[wr_ptr].data  <= commit_rd_data;
    end
  end

  assign count    = count_q;
  assign rd_pc    = rd_q.pc;
  assign rd_instr = rd_q.instr;
  assign rd_we    = rd_q.we;
  assign rd_rd    = rd_q.rd;
  assign rd_data  = rd_q.data;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Self-checking bench for commit_trace_buffer: table vectors, directed corner
// sequences and randomized traffic compared against a queue-based reference model.
module tb_commit_trace_buffer;

  localparam int DEPTH     = 16;
  localparam int POST_TRIG = 4;
  localparam int XLEN      = 32;
  localparam int CW        = $clog2(DEPTH) + 1;

  logic            clk = 1'b0;
  logic            reset;
  logic            commit_valid, commit_rd_we, trig_en, clear, rd_req;
  logic [XLEN-1:0] commit_pc, commit_rd_data, trig_pc;
  logic [31:0]     commit_instr;
  logic [4:0]      commit_rd;
  logic            rd_valid, rd_we, full, empty, triggered, frozen;
  logic [XLEN-1:0] rd_pc, rd_data;
  logic [31:0]     rd_instr;
  logic [4:0]      rd_rd;
  logic [CW-1:0]   count;
  logic [15:0]     overflow_cnt;

  commit_trace_buffer #(.DEPTH(DEPTH), .POST_TRIG(POST_TRIG), .XLEN(XLEN)) dut (
    .clk(clk), .reset(reset),
    .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_instr(commit_instr),
    .commit_rd_we(commit_rd_we), .commit_rd(commit_rd), .commit_rd_data(commit_rd_data),
    .trig_en(trig_en), .trig_pc(trig_pc), .clear(clear), .rd_req(rd_req),
    .rd_valid(rd_valid), .rd_pc(rd_pc), .rd_instr(rd_instr), .rd_we(rd_we),
    .rd_rd(rd_rd), .rd_data(rd_data), .count(count), .full(full), .empty(empty),
    .overflow_cnt(overflow_cnt), .triggered(triggered), .frozen(frozen)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        ten;
    logic [31:0] tpc;
    logic        clr;
    logic        req;
  } in_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
  } rec_t;

  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic        req;
    int          exp_count;
    logic        exp_valid;
    logic [31:0] exp_pc;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // Reference model: a bounded queue plus a few scalars describing the trigger.
  rec_t m_q[$];
  rec_t m_rd;
  bit   m_rd_valid;
  int   m_ovf;
  bit   m_trig;
  int   m_mode;   // 0 capturing, 1 counting down after trigger, 2 frozen
  int   m_rem;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic in_t idle();
    in_t i;
    i.v = 0; i.pc = 0; i.instr = 32'h0000_0033; i.we = 0; i.rd = 0; i.data = 0;
    i.ten = 0; i.tpc = 0; i.clr = 0; i.req = 0;
    return i;
  endfunction

  function automatic in_t commit(input logic [31:0] pc);
    in_t i = idle();
    i.v = 1; i.pc = pc; i.we = 1; i.rd = 5'd1; i.data = pc ^ 32'hA5A5_0000;
    return i;
  endfunction

  function automatic in_t pop_in();
    in_t i = idle();
    i.req = 1;
    return i;
  endfunction

  function automatic in_t clr_in();
    in_t i = idle();
    i.clr = 1;
    return i;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_rd = '0; m_rd_valid = 0; m_ovf = 0; m_trig = 0; m_mode = 0; m_rem = 0;
  endtask

  task automatic model_step(input in_t i);
    bit   nop;
    rec_t r;
    if (i.clr) begin
      m_q.delete(); m_rd_valid = 0; m_ovf = 0; m_trig = 0; m_mode = 0; m_rem = 0;
      return;
    end
`ifdef TRACE_SKIP_NOP_EN
    nop = (i.instr == 32'h0000_0013);
`else
    nop = 0;
`endif
    m_rd_valid = (i.req && m_q.size() > 0);
    if (m_rd_valid) m_rd = m_q.pop_front();
    if (i.v && m_mode != 2) begin
      if (!nop) begin
        if (m_q.size() < DEPTH) begin
          r.pc = i.pc; r.instr = i.instr; r.we = i.we && (i.rd != 0);
          r.rd = i.rd; r.data = i.data;
          m_q.push_back(r);
        end else if (m_ovf < 65535) begin
          m_ovf++;
        end
      end
      if (m_mode == 0 && i.ten && i.pc == i.tpc) begin
        m_trig = 1;
        m_rem  = POST_TRIG;
        m_mode = (POST_TRIG == 0) ? 2 : 1;
      end else if (m_mode == 1 && !nop) begin
        m_rem--;
        if (m_rem == 0) m_mode = 2;
      end
    end
  endtask

  task automatic compare_all();
    check("rd_valid", rd_valid, m_rd_valid);
    check("rd_pc", rd_pc, m_rd.pc);
    check("rd_instr", rd_instr, m_rd.instr);
    check("rd_we", rd_we, m_rd.we);
    check("rd_rd", rd_rd, m_rd.rd);
    check("rd_data", rd_data, m_rd.data);
    check("count", count, m_q.size());
    check("full", full, m_q.size() == DEPTH);
    check("empty", empty, m_q.size() == 0);
    check("overflow_cnt", overflow_cnt, m_ovf);
    check("triggered", triggered, m_trig);
    check("frozen", frozen, m_mode == 2);
  endtask

  task automatic cycle(input in_t i);
    commit_valid = i.v; commit_pc = i.pc; commit_instr = i.instr; commit_rd_we = i.we;
    commit_rd = i.rd; commit_rd_data = i.data; trig_en = i.ten; trig_pc = i.tpc;
    clear = i.clr; rd_req = i.req;
    @(posedge clk);
    #1;
    model_step(i);
    compare_all();
  endtask

  vec_t vecs[7];

  initial begin
    logic [31:0] last_pc;
    in_t         t;

    vecs[0] = '{1, 32'h00, 0, 1, 0, 32'h0};
    vecs[1] = '{1, 32'h04, 0, 2, 0, 32'h0};
    vecs[2] = '{1, 32'h08, 0, 3, 0, 32'h0};
    vecs[3] = '{0, 32'h00, 1, 2, 1, 32'h00};
    vecs[4] = '{0, 32'h00, 1, 1, 1, 32'h04};
    vecs[5] = '{0, 32'h00, 1, 0, 1, 32'h08};
    vecs[6] = '{0, 32'h00, 1, 0, 0, 32'h08};

    t = idle();
    commit_valid = t.v; commit_pc = t.pc; commit_instr = t.instr; commit_rd_we = t.we;
    commit_rd = t.rd; commit_rd_data = t.data; trig_en = t.ten; trig_pc = t.tpc;
    clear = t.clr; rd_req = t.req;
    reset = 1'b0;
    model_reset();
    #22;
    compare_all();
    reset = 1'b1;
    @(posedge clk); #1;

    // Table: three commits then three pops and one pop while empty.
    for (int k = 0; k < 7; k++) begin
      t = idle();
      if (vecs[k].v) t = commit(vecs[k].pc);
      t.req = vecs[k].req;
      cycle(t);
      check($sformatf("vec%0d count", k), count, vecs[k].exp_count);
      check($sformatf("vec%0d rd_valid", k), rd_valid, vecs[k].exp_valid);
      check($sformatf("vec%0d rd_pc", k), rd_pc, vecs[k].exp_pc);
    end

    // 20 commits into 16 entries, then drain in order.
    cycle(clr_in());
    for (int k = 0; k < 20; k++) cycle(commit(32'(k * 4)));
    check("fill full", full, 1);
    check("fill overflow", overflow_cnt, 4);
    for (int k = 0; k < 16; k++) begin
      cycle(pop_in());
      check("drain pc", rd_pc, 32'(k * 4));
    end
    check("drain empty", empty, 1);

    // Trigger at 0x20 with POST_TRIG commits afterwards.
    cycle(clr_in());
    for (int k = 0; k < 18; k++) begin
      t = commit(32'(k * 4));
      t.ten = 1; t.tpc = 32'h20;
      cycle(t);
    end
    check("trig triggered", triggered, 1);
    check("trig frozen", frozen, 1);
    check("trig count", count, 13);
    for (int k = 0; k < 13; k++) begin
      cycle(pop_in());
      check("trig drain pc", rd_pc, 32'(k * 4));
    end

    // Full buffer with a simultaneous commit and pop.
    cycle(clr_in());
    for (int k = 0; k < 16; k++) cycle(commit(32'h1000 + 32'(k * 4)));
    t = commit(32'h2000);
    t.req = 1;
    cycle(t);
    check("simul count", count, 16);
    check("simul overflow", overflow_cnt, 0);
    last_pc = 32'h0;
    for (int k = 0; k < 16; k++) begin
      cycle(pop_in());
      last_pc = rd_pc;
    end
    check("simul newest", last_pc, 32'h2000);

    // x0 writes are filtered.
    cycle(clr_in());
    t = commit(32'h40); t.rd = 5'd0; t.we = 1; t.data = 32'h55;
    cycle(t);
    t = commit(32'h44); t.rd = 5'd5; t.we = 1; t.data = 32'hDEAD_BEEF;
    cycle(t);
    cycle(pop_in());
    check("x0 rd_we", rd_we, 0);
    cycle(pop_in());
    check("r5 rd_we", rd_we, 1);
    check("r5 rd_rd", rd_rd, 5);
    check("r5 rd_data", rd_data, 32'hDEAD_BEEF);

    // Asynchronous reset taken mid-POST.
    cycle(clr_in());
    for (int k = 0; k < 7; k++) begin
      t = commit(32'(k * 4));
      t.ten = 1; t.tpc = 32'h18;
      cycle(t);
    end
    check("pre-reset count", count, 7);
    check("pre-reset triggered", triggered, 1);
    check("pre-reset frozen", frozen, 0);
    #3;
    reset = 1'b0;
    #1;
    model_reset();
    check("async count", count, 0);
    check("async triggered", triggered, 0);
    check("async frozen", frozen, 0);
    check("async empty", empty, 1);
    @(posedge clk); #1;
    reset = 1'b1;
    compare_all();
`ifdef TRACE_SKIP_NOP_EN
    t = commit(32'h80); t.instr = 32'h0000_0013;
    cycle(t);
    check("nop count", count, 0);
`endif
    cycle(commit(32'h84));
    cycle(pop_in());
    check("post-reset first pc", rd_pc, 32'h84);

    // Randomized traffic against the model.
    for (int k = 0; k < 4000; k++) begin
      t = idle();
      t.v     = ($urandom_range(0, 9) < 7);
      t.pc    = 32'($urandom_range(0, 31)) << 2;
      t.instr = ($urandom_range(0, 7) == 0) ? 32'h0000_0013 : $urandom;
      t.we    = 1'($urandom_range(0, 1));
      t.rd    = 5'($urandom_range(0, 31));
      t.data  = $urandom;
      t.ten   = 1'($urandom_range(0, 1));
      t.tpc   = 32'($urandom_range(0, 31)) << 2;
      t.clr   = ($urandom_range(0, 149) == 0);
      t.req   = ($urandom_range(0, 9) < 4);
      cycle(t);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
